toggle_event_decoder: RTL and testbench

Receiving end of the toggle-encoded event line driven by the team's T flip-flop. Each level change on `t_in` is one event. The block recovers those events as single-cycle edges, queues them in a saturating pending counter, and presents them to a consumer over a valid/ready handshake. It also keeps a running total of accepted events and a sticky overflow flag.

---
 rtl/toggle_dec_pkg.sv | 25 ++
 rtl/toggle_edge_detect.sv | 81 ++++++++
 rtl/toggle_event_decoder.sv | 73 +++++++
 tb/tb_toggle_event_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_dec_pkg.sv
// Shared definitions for the toggle-encoded event decoder.
// Build option: define TOGGLE_DEC_SYNC_EN when t_in is asynchronous to clk;
// this selects a 2-flop synchronizer instead of a single capture register.
package toggle_dec_pkg;

  // Decoder FSM: PRIME fills the input stages, RUN credits edges.
  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } dec_state_t;

  // Number of register stages between t_in and t_q.
`ifdef TOGGLE_DEC_SYNC_EN
  localparam int N_STG = 2;
`else
  localparam int N_STG = 1;
`endif

  // Prime counter must hold values 0..N_STG.
  localparam int PRIME_W = 2;

  localparam int CNT_W_DEF = 4;
  localparam int TOT_W_DEF = 16;

endpackage

// File: rtl/toggle_edge_detect.sv
// Input stages, previous-level register and PRIME/RUN FSM for the toggle line.
// Produces a single-cycle t_edge for every level change of t_in once the
// stages hold real samples, so a line sitting high at reset release is not
// mistaken for an event.
// Build option: TOGGLE_DEC_SYNC_EN (see toggle_dec_pkg).
module toggle_edge_detect
  import toggle_dec_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic t_in,
  output logic t_edge
);

  logic [N_STG-1:0]   stg;
  logic               t_q;
  logic               t_prev;
  logic [PRIME_W-1:0] prime_cnt;
  dec_state_t         state;
  dec_state_t         state_nxt;

  assign t_q = stg[N_STG-1];

  // Capture/synchronizer chain: stg[0] samples t_in, last stage is t_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg[0] <= t_in;
      for (int i = 1; i < N_STG; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  // Previous t_q follows every cycle in both PRIME and RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_prev <= 1'b0;
    end else begin
      t_prev <= t_q;
    end
  end

  // Counts cycles spent in PRIME since reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prime_cnt <= '0;
    end else if (state == PRIME) begin
      prime_cnt <= prime_cnt + PRIME_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= PRIME;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave PRIME once t_q and t_prev both hold post-reset samples.
  always_comb begin
    state_nxt = state;
    case (state)
      PRIME:   if (prime_cnt == PRIME_W'(N_STG)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = PRIME;
    endcase
  end

  // Output: edges are only credited in RUN.
  always_comb begin
    t_edge = 1'b0;
    if (state == RUN) begin
      t_edge = t_q ^ t_prev;
    end
  end

endmodule

// File: rtl/toggle_event_decoder.sv
// Toggle-encoded event receiver: recovers events from t_in level changes,
// queues them in a saturating pending counter, and hands them out over a
// valid/ready handshake while keeping a wrapping total and a sticky overflow.
// Build option: TOGGLE_DEC_SYNC_EN (see toggle_dec_pkg).
//
// Handshake: evt_valid is high whenever pending is nonzero and only falls
// after a pop; one event is consumed on every clock edge where evt_valid and
// evt_ready are both high.
module toggle_event_decoder
  import toggle_dec_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TOT_W = TOT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t_in,
  input  logic             en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic [TOT_W-1:0] total,
  output logic             overflow,
  input  logic             clr_ovf
);

  logic t_edge;
  logic evt;
  logic pop;
  logic full;
  logic drop;

  toggle_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .t_in   (t_in),
    .t_edge (t_edge)
  );

  assign evt       = t_edge & en;
  assign evt_valid = (pending != '0);
  assign pop       = evt_valid & evt_ready;
  assign full      = &pending;
  // A pop in the same cycle frees a slot, so a full queue only drops without one.
  assign drop      = evt & full & ~pop;

  // Pending queue depth and accepted-event total.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      total   <= '0;
    end else if (evt && pop) begin
      total <= total + TOT_W'(1);
    end else if (evt && !full) begin
      pending <= pending + CNT_W'(1);
      total   <= total + TOT_W'(1);
    end else if (!evt && pop) begin
      pending <= pending - CNT_W'(1);
    end
  end

  // Sticky overflow; a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a model that
// works from the sampled history of t_in.
module tb_toggle_event_decoder;
  import toggle_dec_pkg::*;

  localparam int CNT_W = 4;
  localparam int TOT_W = 16;
  localparam int MAXP  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             t_in;
  logic             en;
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] pending;
  logic [TOT_W-1:0] total;
  logic             overflow;
  logic             clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  toggle_event_decoder #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .t_in      (t_in),
    .en        (en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pending   (pending),
    .total     (total),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // samp_q[k] is the t_in value sampled at the (k+1)-th edge after reset
  // release. A change between consecutive samples i-1 and i (i >= 2, 1-based)
  // is credited N_STG edges after sample i, gated by en at that edge.
  bit samp_q[$];
  int m_pending = 0;
  int m_total   = 0;
  bit m_ovf     = 1'b0;
  int m_j;
  bit m_ev, m_pop, m_drop;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pending = 0;
      m_total   = 0;
      m_ovf     = 1'b0;
      samp_q.delete();
    end else begin
      samp_q.push_back(t_in);
      m_j  = samp_q.size();
      m_ev = 1'b0;
      if (m_j >= N_STG + 2)
        m_ev = (samp_q[m_j-N_STG-1] != samp_q[m_j-N_STG-2]) && en;
      m_pop  = (m_pending != 0) && evt_ready;
      m_drop = 1'b0;
      if (m_ev && m_pop) begin
        m_total = m_total + 1;
      end else if (m_ev && m_pending == MAXP) begin
        m_drop = 1'b1;
      end else if (m_ev) begin
        m_pending = m_pending + 1;
        m_total   = m_total + 1;
      end else if (m_pop) begin
        m_pending = m_pending - 1;
      end
      m_total = m_total % (1 << TOT_W);
      if (m_drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_pending",  pending,   m_pending);
      check("cyc_total",    total,     m_total);
      check("cyc_evt_valid", evt_valid, (m_pending != 0));
      check("cyc_overflow", overflow,  m_ovf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle();
    t_in = ~t_in;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    cyc(n);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int hold;

  initial begin
    rst_n     = 1'b0;
    t_in      = 1'b1;
    en        = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    cyc(3);
    chk_en = 1'b1;

    // Reset values with t_in high, then release: no spurious event.
    check("rst_pending", pending, 0);
    check("rst_total", total, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("release_pending", pending, 0);
      check("release_total", total, 0);
    end

    // Three toggles, no consumer; evt_valid rises N_STG edges after capture.
    toggle();
    cyc(N_STG);
    check("latency_valid_low", evt_valid, 0);
    cyc(1);
    check("latency_valid_high", evt_valid, 1);
    cyc(2 - N_STG + 1);
    toggle();
    cyc(3);
    toggle();
    cyc(N_STG + 2);
    check("three_pending", pending, 3);
    check("three_total", total, 3);
    evt_ready = 1'b1;
    cyc(1);
    check("drain_2", pending, 2);
    cyc(1);
    check("drain_1", pending, 1);
    cyc(1);
    check("drain_0", pending, 0);
    check("drain_valid", evt_valid, 0);
    evt_ready = 1'b0;

    // Overflow: 16 toggles into a 15-deep queue.
    do_reset(2);
    cyc(N_STG + 2);
    for (int i = 0; i < 16; i++) begin
      toggle();
      cyc(2);
    end
    cyc(N_STG + 1);
    check("ovf_pending", pending, 15);
    check("ovf_total", total, 15);
    check("ovf_flag", overflow, 1);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    // Drop lands on the same edge as clr_ovf: set wins.
    toggle();
    cyc(N_STG);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_drop_total", total, 15);

    // Event and pop together at full: no drop.
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    toggle();
    cyc(N_STG);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("evpop_pending", pending, 15);
    check("evpop_total", total, 16);
    check("evpop_overflow", overflow, 0);

    // en gating: four ignored toggles, then one counted.
    do_reset(2);
    cyc(N_STG + 2);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      toggle();
      cyc(2);
    end
    cyc(N_STG + 1);
    en = 1'b1;
    toggle();
    cyc(N_STG + 2);
    check("en_pending", pending, 1);
    check("en_total", total, 1);

    // Reset mid-operation with five pending.
    for (int i = 0; i < 4; i++) begin
      toggle();
      cyc(2);
    end
    cyc(N_STG + 1);
    check("mid_pending5", pending, 5);
    do_reset(1);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_total", total, 0);
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_overflow", overflow, 0);
    cyc(N_STG + 1);
    toggle();
    cyc(N_STG + 2);
    check("mid_after_pending", pending, 1);
    check("mid_after_total", total, 1);

    // Randomized traffic: low-ready phase builds overflow, then high-ready.
    do_reset(2);
    hold = N_STG;
    for (int c = 0; c < 2400; c++) begin
      if (hold >= N_STG && $urandom_range(0, 2) == 0) begin
        t_in = ~t_in;
        hold = 1;
      end else begin
        hold++;
      end
      en        = ($urandom_range(0, 7) != 0);
      evt_ready = (c < 1200) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 399) != 0);
      cyc(1);
    end
    rst_n     = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    cyc(4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
